// File: rtl/updown_cnter_load_pkg.sv
// Shared constants for the loadable up/down counter: direction encoding and default width.
package updown_cnter_load_pkg;

  typedef enum logic {
    CNT_DOWN = 1'b0,
    CNT_UP   = 1'b1
  } cnt_dir_e;

  localparam int CNT_WIDTH_DEF = 4;

endpackage

// File: rtl/updown_cnter_load_if.sv
// Control/data bundle of one counter instance; the counter is the slave side.
interface updown_cnter_load_if #(
  parameter int WIDTH = 4
);
  logic             clr_i;
  logic             load_i;
  logic             en_i;
  logic             up_i;
  logic [WIDTH-1:0] d_i;
  logic [WIDTH-1:0] q_o;
  logic             co_o;
  logic             wrap_o;

  modport slave (
    input  clr_i, load_i, en_i, up_i, d_i,
    output q_o, co_o, wrap_o
  );

  modport master (
    output clr_i, load_i, en_i, up_i, d_i,
    input  q_o, co_o, wrap_o
  );
endinterface

// File: rtl/updown_cnter_load_stage.sv
// One counter bit: toggle flop with sync clear/load and up/down toggle-chain outputs.
module cnter_stage (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic load_i,
  input  logic d_i,
  input  logic t_i,
  output logic q_o,
  output logic t_up_o,
  output logic t_dn_o
);

  logic r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     r_q <= 1'b0;
    else if (clr_i)  r_q <= 1'b0;
    else if (load_i) r_q <= d_i;
    else if (t_i)    r_q <= ~r_q;
  end

  assign q_o    = r_q;
  // Next bit toggles on increment when this one is 1, on decrement when it is 0.
  assign t_up_o = t_i & r_q;
  assign t_dn_o = t_i & ~r_q;

endmodule

// File: rtl/updown_cnter_load.sv
// Synchronous up/down counter with parallel load, sync clear, cascadable carry/borrow and wrap pulse.
module updown_cnter_load
  import updown_cnter_load_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  updown_cnter_load_if.slave  bus
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_t_up;
  logic [WIDTH-1:0] w_t_dn;
  logic             w_co;
  logic             r_wrap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    if (i == 0) begin : g_lsb
      assign w_t[i] = bus.en_i;
    end else begin : g_chain
      assign w_t[i] = (bus.up_i == CNT_UP) ? w_t_up[i-1] : w_t_dn[i-1];
    end

    cnter_stage u_stage (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (bus.clr_i),
      .load_i (bus.load_i),
      .d_i    (bus.d_i[i]),
      .t_i    (w_t[i]),
      .q_o    (w_q[i]),
      .t_up_o (w_t_up[i]),
      .t_dn_o (w_t_dn[i])
    );
  end

  // Chain end is en & (all ones / all zeros); clear and load suppress it so they never wrap.
  assign w_co = ~bus.clr_i & ~bus.load_i &
                ((bus.up_i == CNT_UP) ? w_t_up[WIDTH-1] : w_t_dn[WIDTH-1]);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_wrap <= 1'b0;
    else         r_wrap <= w_co;
  end

  assign bus.q_o    = w_q;
  assign bus.co_o   = w_co;
  assign bus.wrap_o = r_wrap;

endmodule

// File: tb/tb_updown_cnter_load.sv
// Bench for updown_cnter_load: directed table, hand sequences, cascade, and random vs. arithmetic model.
module tb_updown_cnter_load;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  updown_cnter_load_if #(.WIDTH(4)) bus ();
  updown_cnter_load_if #(.WIDTH(4)) lo ();
  updown_cnter_load_if #(.WIDTH(4)) hi ();

  updown_cnter_load #(.WIDTH(4)) dut    (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  updown_cnter_load #(.WIDTH(4)) dut_lo (.clk_i(clk), .rst_ni(rst_n), .bus(lo));
  updown_cnter_load #(.WIDTH(4)) dut_hi (.clk_i(clk), .rst_ni(rst_n), .bus(hi));

  assign hi.en_i = lo.co_o;

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int q_m = 0;
  logic wrap_m = 1'b0;

  typedef struct {
    logic       c, l, e, u;
    logic [3:0] d;
    logic [3:0] q;
    logic       co;
    logic       wr;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Starts at edge+1, ends at the following edge+1; checks co before and q/wrap after the edge.
  task automatic step(input logic c, l, e, u, input logic [3:0] d, output logic co_seen);
    logic co_exp;
    bus.clr_i = c; bus.load_i = l; bus.en_i = e; bus.up_i = u; bus.d_i = d;
    #1;
    co_exp  = e && !c && !l && (u ? (q_m == 15) : (q_m == 0));
    co_seen = bus.co_o;
    chk("co", {31'b0, bus.co_o}, {31'b0, co_exp});
    @(posedge clk);
    if (c)      q_m = 0;
    else if (l) q_m = int'(d);
    else if (e) q_m = u ? (q_m + 1) % 16 : (q_m + 15) % 16;
    wrap_m = co_exp;
    #1;
    chk("q", {28'b0, bus.q_o}, q_m);
    chk("wrap", {31'b0, bus.wrap_o}, {31'b0, wrap_m});
  endtask

  task automatic cstep(input logic c, l, e, u, input logic [7:0] d, input logic [7:0] exp_q);
    lo.clr_i = c; hi.clr_i = c; lo.load_i = l; hi.load_i = l;
    lo.up_i = u; hi.up_i = u; lo.d_i = d[3:0]; hi.d_i = d[7:4]; lo.en_i = e;
    @(posedge clk);
    #1;
    chk("cascade_q", {24'b0, hi.q_o, lo.q_o}, {24'b0, exp_q});
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("async_q", {28'b0, bus.q_o}, 0);
    chk("async_wrap", {31'b0, bus.wrap_o}, 0);
    q_m = 0; wrap_m = 1'b0;
    #2 rst_n = 1'b1;
    bus.clr_i = 0; bus.load_i = 0; bus.en_i = 0; bus.up_i = 0; bus.d_i = 0;
    @(posedge clk);
    #1;
    chk("post_rst_q", {28'b0, bus.q_o}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic co;
    int dn_exp[5];
    dn_exp = '{2, 1, 0, 15, 14};

    vt[0]  = '{1, 1, 1, 1, 4'd10, 4'd0,  0, 0};
    vt[1]  = '{0, 1, 1, 1, 4'd10, 4'd10, 0, 0};
    vt[2]  = '{0, 1, 1, 1, 4'd15, 4'd15, 0, 0};
    vt[3]  = '{0, 1, 1, 1, 4'd15, 4'd15, 0, 0};
    vt[4]  = '{0, 0, 1, 1, 4'd0,  4'd0,  1, 1};
    vt[5]  = '{0, 0, 0, 1, 4'd0,  4'd0,  0, 0};
    vt[6]  = '{0, 1, 0, 0, 4'd7,  4'd7,  0, 0};
    vt[7]  = '{0, 0, 0, 1, 4'd3,  4'd7,  0, 0};
    vt[8]  = '{0, 0, 0, 0, 4'd3,  4'd7,  0, 0};
    vt[9]  = '{0, 0, 0, 1, 4'd3,  4'd7,  0, 0};
    vt[10] = '{0, 0, 1, 1, 4'd0,  4'd8,  0, 0};
    vt[11] = '{0, 0, 1, 0, 4'd0,  4'd7,  0, 0};
    vt[12] = '{0, 0, 1, 1, 4'd0,  4'd8,  0, 0};
    vt[13] = '{0, 0, 1, 0, 4'd0,  4'd7,  0, 0};
    vt[14] = '{1, 0, 1, 0, 4'd0,  4'd0,  0, 0};
    vt[15] = '{0, 0, 1, 0, 4'd0,  4'd15, 1, 1};
    vt[16] = '{1, 0, 1, 1, 4'd0,  4'd0,  0, 0};
    vt[17] = '{0, 1, 1, 0, 4'd0,  4'd0,  0, 0};

    bus.clr_i = 0; bus.load_i = 0; bus.en_i = 0; bus.up_i = 0; bus.d_i = 0;
    lo.clr_i = 0; lo.load_i = 0; lo.en_i = 0; lo.up_i = 0; lo.d_i = 0;
    hi.clr_i = 0; hi.load_i = 0; hi.up_i = 0; hi.d_i = 0;

    // Power-on reset held across a clock edge.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_q", {28'b0, bus.q_o}, 0);
    chk("rst_wrap", {31'b0, bus.wrap_o}, 0);
    #3;
    chk("rst_q_edge", {28'b0, bus.q_o}, 0);
    chk("rst_co_down", {31'b0, bus.co_o}, 0);
    #1 rst_n = 1'b1;
    #1;
    chk("rel_q", {28'b0, bus.q_o}, 0);
    @(posedge clk);
    #1;

    // Up count through wrap.
    step(1, 0, 0, 1, 0, co);
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 1, 1, 0, co);
      chk("up_seq_q", {28'b0, bus.q_o}, (i + 1) % 16);
      chk("up_seq_wrap", {31'b0, bus.wrap_o}, (i == 15) ? 1 : 0);
    end

    // Down count through wrap.
    step(0, 1, 1, 0, 4'd3, co);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 0, co);
      chk("dn_seq_q", {28'b0, bus.q_o}, dn_exp[i]);
      chk("dn_seq_co", {31'b0, co}, (i == 3) ? 1 : 0);
      chk("dn_seq_wrap", {31'b0, bus.wrap_o}, (i == 3) ? 1 : 0);
    end

    // Priority / hold / direction table.
    for (int i = 0; i < 18; i++) begin
      step(vt[i].c, vt[i].l, vt[i].e, vt[i].u, vt[i].d, co);
      chk($sformatf("tbl%0d_co", i), {31'b0, co}, {31'b0, vt[i].co});
      chk($sformatf("tbl%0d_q", i), {28'b0, bus.q_o}, {28'b0, vt[i].q});
      chk($sformatf("tbl%0d_wrap", i), {31'b0, bus.wrap_o}, {31'b0, vt[i].wr});
    end

    // Asynchronous reset at q = 9, then with a wrap pulse pending.
    step(0, 1, 0, 0, 4'd9, co);
    async_reset();
    step(0, 1, 0, 0, 4'd15, co);
    step(0, 0, 1, 1, 0, co);
    chk("pend_wrap", {31'b0, bus.wrap_o}, 1);
    async_reset();

    // Cascade of two 4-bit stages as an 8-bit counter.
    cstep(0, 1, 0, 1, 8'h0F, 8'h0F);
    cstep(0, 0, 1, 1, 8'h00, 8'h10);
    cstep(0, 0, 1, 0, 8'h00, 8'h0F);
    cstep(0, 1, 0, 0, 8'h00, 8'h00);
    lo.en_i = 1; lo.up_i = 0; hi.up_i = 0; lo.load_i = 0; hi.load_i = 0;
    #1;
    chk("cascade_hi_co", {31'b0, hi.co_o}, 1);
    cstep(0, 0, 1, 0, 8'h00, 8'hFF);
    chk("cascade_hi_wrap", {31'b0, hi.wrap_o}, 1);
    cstep(0, 0, 0, 0, 8'h00, 8'hFF);
    chk("cascade_hi_wrap_end", {31'b0, hi.wrap_o}, 0);

    // Random traffic against the arithmetic model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(15) == 0), ($urandom_range(7) == 0), ($urandom_range(3) != 0),
           1'($urandom_range(1)), 4'($urandom_range(15)), co);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
